// File: rtl/instr_encode.sv
// Instruction-stream encoder: packs R/I/J descriptors into 32-bit words and
// writes them to consecutive instruction-memory addresses under a handshake.
module instr_encode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  fmt_i,
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] imm_i,
  input  logic        sign_ext_i,
  input  logic [25:0] target_i,
  input  logic        last_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  input  logic        imem_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_count_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_e;
  typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_J = 2'd2, FMT_BAD = 2'd3} fmt_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        last_q;
  logic        err_q;
  logic [15:0] word_cnt_q;
  logic [7:0]  err_cnt_q;

  logic [31:0] word_d;
  logic        word_ok_d;
  logic        imm_fits;

  // The immediate must be representable in 16 bits under the chosen signedness.
  assign imm_fits = sign_ext_i ? (imm_i[31:16] == {16{imm_i[15]}})
                               : (imm_i[31:16] == 16'h0000);

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    word_d    = 32'h0000_0000;
    word_ok_d = 1'b0;
    unique case (fmt_e'(fmt_i))
      FMT_R: begin
        word_d    = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
        word_ok_d = 1'b1;
      end
      FMT_I: begin
        word_d    = {op_i, rs_i, rt_i, imm_i[15:0]};
        word_ok_d = (op_i != 6'h00) && (op_i != 6'h02) && (op_i != 6'h03) && imm_fits;
      end
      FMT_J: begin
        word_d    = {op_i, target_i};
        word_ok_d = (op_i == 6'h02) || (op_i == 6'h03);
      end
      FMT_BAD: begin
        word_d    = 32'h0000_0000;
        word_ok_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= 16'h0000;
      err_cnt_q  <= 8'h00;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_ACCEPT;
            addr_q     <= base_addr_i;
            word_cnt_q <= 16'h0000;
            err_cnt_q  <= 8'h00;
          end
        end
        S_ACCEPT: begin
          if (in_valid_i) begin
            if (word_ok_d) begin
              wdata_q <= word_d;
              last_q  <= last_i;
              we_q    <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              err_q     <= 1'b1;
              err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
              state_q   <= last_i ? S_DONE : S_ACCEPT;
            end
          end
        end
        S_WRITE: begin
          // Request stays frozen until the memory acknowledges it.
          if (imem_ack_i && we_q) begin
            we_q       <= 1'b0;
            addr_q     <= addr_q + 32'd4;
            word_cnt_q <= (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
            state_q    <= last_q ? S_DONE : S_ACCEPT;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = (state_q == S_ACCEPT);
  assign busy_o       = (state_q == S_ACCEPT) || (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign word_count_o = word_cnt_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_instr_encode.sv
// Directed self-checking bench for instr_encode: encodings, rejects, stalls,
// multi-word programs, saturation, wrap and reset during a pending write.
module tb_instr_encode;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  fmt_i;
  logic [5:0]  op_i;
  logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
  logic [5:0]  funct_i;
  logic [31:0] imm_i;
  logic        sign_ext_i;
  logic [25:0] target_i;
  logic        last_i;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        imem_ack_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] word_count_o;
  logic [7:0]  err_count_o;

  int n_checks = 0;
  int n_errors = 0;

  instr_encode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .fmt_i        (fmt_i),
    .op_i         (op_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .rd_i         (rd_i),
    .shamt_i      (shamt_i),
    .funct_i      (funct_i),
    .imm_i        (imm_i),
    .sign_ext_i   (sign_ext_i),
    .target_i     (target_i),
    .last_i       (last_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .imem_ack_i   (imem_ack_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .word_count_o (word_count_o),
    .err_count_o  (err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic desc(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
                      input logic [5:0] funct, input logic [31:0] imm, input logic sx,
                      input logic [25:0] target, input logic last);
    fmt_i = fmt; op_i = op; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = shamt;
    funct_i = funct; imm_i = imm; sign_ext_i = sx; target_i = target; last_i = last;
    in_valid_i = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start_i = 1'b0; base_addr_i = '0; in_valid_i = 1'b0;
    fmt_i = '0; op_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0;
    funct_i = '0; imm_i = '0; sign_ext_i = 1'b0; target_i = '0; last_i = 1'b0;
    imem_ack_i = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_we",    32'(imem_we_o), 32'd0);
    check("rst_addr",  imem_addr_o, 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_ready", 32'(in_ready_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    check("rst_wcnt",  32'(word_count_o), 32'd0);
    check("rst_ecnt",  32'(err_count_o), 32'd0);

    // Start a program
    reset_n = 1'b1; start_i = 1'b1; base_addr_i = 32'h0040_0000;
    tick();
    start_i = 1'b0;
    check("start_busy",  32'(busy_o), 32'd1);
    check("start_ready", 32'(in_ready_o), 32'd1);
    check("start_addr",  imem_addr_o, 32'h0040_0000);

    // R-type, op_i ignored, immediate ack
    desc(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h0, 1'b0, 26'h0, 1'b0);
    tick();
    in_valid_i = 1'b0; imem_ack_i = 1'b1;
    check("r_we",    32'(imem_we_o), 32'd1);
    check("r_addr",  imem_addr_o, 32'h0040_0000);
    check("r_data",  imem_wdata_o, 32'h0022_1820);
    check("r_ready", 32'(in_ready_o), 32'd0);
    tick();
    imem_ack_i = 1'b0;
    check("r_we_off", 32'(imem_we_o), 32'd0);
    check("r_wcnt",   32'(word_count_o), 32'd1);
    check("r_addr+4", imem_addr_o, 32'h0040_0004);

    // I-type with negative immediate, then 3-cycle stall
    desc(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 32'hFFFF_FFFF, 1'b1, 26'h0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("i_data", imem_wdata_o, 32'h2008_FFFF);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_we",    32'(imem_we_o), 32'd1);
      check("stall_addr",  imem_addr_o, 32'h0040_0004);
      check("stall_data",  imem_wdata_o, 32'h2008_FFFF);
      check("stall_ready", 32'(in_ready_o), 32'd0);
    end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    check("i_wcnt", 32'(word_count_o), 32'd2);

    // I-type immediate out of signed 16-bit range
    desc(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 32'h0001_0000, 1'b1, 26'h0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("irng_err",   32'(err_o), 32'd1);
    check("irng_ecnt",  32'(err_count_o), 32'd1);
    check("irng_we",    32'(imem_we_o), 32'd0);
    check("irng_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("irng_err_pulse", 32'(err_o), 32'd0);

    // I-type with a J opcode is rejected
    desc(2'd1, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b0, 26'h0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("iop_ecnt", 32'(err_count_o), 32'd2);
    check("iop_we",   32'(imem_we_o), 32'd0);

    // Unsigned immediate 0xFFFF fits
    desc(2'd1, 6'h0D, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 32'h0000_FFFF, 1'b0, 26'h0, 1'b0);
    tick();
    in_valid_i = 1'b0; imem_ack_i = 1'b1;
    check("iu_data", imem_wdata_o, 32'h3485_FFFF);
    tick();
    imem_ack_i = 1'b0;

    // J-type JAL
    desc(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b0, 26'h010_0000, 1'b0);
    tick();
    in_valid_i = 1'b0; imem_ack_i = 1'b1;
    check("j_data", imem_wdata_o, 32'h0C10_0000);
    check("j_addr", imem_addr_o, 32'h0040_000C);
    tick();
    imem_ack_i = 1'b0;
    check("j_wcnt", 32'(word_count_o), 32'd4);

    // J-type with a bad opcode
    desc(2'd2, 6'h05, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b0, 26'h010_0000, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("jbad_err",  32'(err_o), 32'd1);
    check("jbad_ecnt", 32'(err_count_o), 32'd3);
    check("jbad_we",   32'(imem_we_o), 32'd0);

    // Ack while no write is pending is ignored
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    check("stray_ack_wcnt", 32'(word_count_o), 32'd4);
    check("stray_ack_addr", imem_addr_o, 32'h0040_0010);

    // Invalid format carrying last_i ends the program
    desc(2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b0, 26'h0, 1'b1);
    tick();
    in_valid_i = 1'b0; last_i = 1'b0;
    check("bad_err",  32'(err_o), 32'd1);
    check("bad_done", 32'(done_o), 32'd1);
    check("bad_busy", 32'(busy_o), 32'd0);
    check("bad_ecnt", 32'(err_count_o), 32'd4);
    tick();
    check("idle_done", 32'(done_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_wcnt", 32'(word_count_o), 32'd4);
    check("idle_ecnt", 32'(err_count_o), 32'd4);

    // Three-word program; start_i held high in ACCEPT must not recapture the base
    start_i = 1'b1; base_addr_i = 32'h0040_0000;
    tick();
    base_addr_i = 32'h1234_5678;
    check("p3_wcnt_clr", 32'(word_count_o), 32'd0);
    check("p3_ecnt_clr", 32'(err_count_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      desc(2'd0, 6'h00, 5'd1, 5'd2, 5'(k), 5'd0, 6'h20, 32'h0, 1'b0, 26'h0, k == 2);
      tick();
      in_valid_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b1;
      check("p3_addr", imem_addr_o, 32'h0040_0000 + 32'(4 * k));
      check("p3_data", imem_wdata_o, 32'h0022_0020 | 32'(k << 11));
      check("p3_done_early", 32'(done_o), 32'd0);
      tick();
      imem_ack_i = 1'b0;
    end
    check("p3_done", 32'(done_o), 32'd1);
    check("p3_wcnt", 32'(word_count_o), 32'd3);
    tick();
    check("p3_done_pulse", 32'(done_o), 32'd0);

    // Address wraps modulo 2^32; error counter saturates at 0xFF
    start_i = 1'b1; base_addr_i = 32'hFFFF_FFFC;
    tick();
    start_i = 1'b0;
    desc(2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b0, 26'h0, 1'b0);
    tick();
    in_valid_i = 1'b0; imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    check("wrap_addr", imem_addr_o, 32'h0000_0000);
    desc(2'd3, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b0, 26'h0, 1'b0);
    for (int n = 0; n < 260; n++) tick();
    check("sat_ecnt", 32'(err_count_o), 32'hFF);
    last_i = 1'b1;
    tick();
    in_valid_i = 1'b0; last_i = 1'b0;
    check("sat_ecnt_hold", 32'(err_count_o), 32'hFF);
    check("sat_done", 32'(done_o), 32'd1);
    tick();

    // Reset while a write is pending, colliding with ack/start/handshake
    start_i = 1'b1; base_addr_i = 32'h0040_0000;
    tick();
    start_i = 1'b0;
    desc(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h0, 1'b0, 26'h0, 1'b0);
    tick();
    check("pre_rst_we", 32'(imem_we_o), 32'd1);
    reset_n = 1'b0; imem_ack_i = 1'b1; start_i = 1'b1;
    tick();
    check("wr_rst_we",   32'(imem_we_o), 32'd0);
    check("wr_rst_busy", 32'(busy_o), 32'd0);
    check("wr_rst_addr", imem_addr_o, 32'd0);
    check("wr_rst_wcnt", 32'(word_count_o), 32'd0);
    check("wr_rst_ecnt", 32'(err_count_o), 32'd0);
    reset_n = 1'b1; imem_ack_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
    tick(); tick();
    check("no_reissue_we",   32'(imem_we_o), 32'd0);
    check("no_reissue_busy", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
